// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame-format limits and the TX state encoding.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a one-entry holding register,
// framed serial output (start, LSB-first data, optional parity, stop) paced by baud_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned          CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic                 STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 hold_par_q, hold_par_d;
    logic                 par_q, par_d;
    logic                 pending_q, pending_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 accept;
    logic                 do_load;

    assign accept = tx_valid && ready_q;

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shreg_d    = shreg_q;
        hold_par_d = hold_par_q;
        par_d      = par_q;
        pending_d  = pending_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        do_load    = 1'b0;

        if (accept) begin
            hold_d     = tx_data;
            hold_par_d = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
            pending_d  = 1'b1;
        end

        if (baud_tick) begin
            unique case (state_q)
                TX_IDLE: begin
                    if (pending_q) do_load = 1'b1;
                end
                TX_START: begin
                    tx_d      = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = '0;
                    state_d   = TX_DATA;
                end
                TX_DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = TX_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = TX_STOP;
                        end
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                TX_PARITY: begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = TX_STOP;
                end
                TX_STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        if (pending_q) do_load = 1'b1;
                        else           state_d = TX_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = TX_IDLE;
            endcase
        end

        // Loading never coincides with acceptance: one needs pending set, the other clear.
        if (do_load) begin
            tx_d      = 1'b0;
            shreg_d   = hold_q;
            par_d     = hold_par_q;
            pending_d = 1'b0;
            state_d   = TX_START;
        end

        ready_d = !pending_d;
        busy_d  = (state_d != TX_IDLE) || pending_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            hold_q     <= '0;
            shreg_q    <= '0;
            hold_par_q <= 1'b0;
            par_q      <= 1'b0;
            pending_q  <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shreg_q    <= shreg_d;
            hold_par_q <= hold_par_d;
            par_q      <= par_d;
            pending_q  <= pending_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four frame formats (8N1, 8E1, 8O1, 8N2) share one baud tick.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic [3:0] tx_valid_a;
    logic [7:0] data_a [4];
    logic [3:0] tx_w;
    logic [3:0] ready_w;
    logic [3:0] busy_w;

    int   n_checks;
    int   n_fails;
    int   tick_cnt;
    logic tick_prev;

    uart_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_a[0]),
        .tx_valid(tx_valid_a[0]), .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_a[1]),
        .tx_valid(tx_valid_a[1]), .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1)) dut_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_a[2]),
        .tx_valid(tx_valid_a[2]), .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_8n2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data_a[3]),
        .tx_valid(tx_valid_a[3]), .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge, tick every 16 cycles.
    task automatic step();
        @(posedge clk);
        #1;
        tick_prev = baud_tick;
        tick_cnt  = (tick_cnt + 1) % 16;
        baud_tick = (tick_cnt == 15);
    endtask

    task automatic next_tick(output int waited);
        logic seen;
        seen   = 1'b0;
        waited = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            waited++;
            seen = tick_prev;
        end
        chk("tick_wait", 32'(seen), 32'd1);
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        if (baud_tick) step();
        data_a[sel]     = d;
        tx_valid_a[sel] = 1'b1;
        step();
        tx_valid_a[sel] = 1'b0;
        chk($sformatf("accept_ready%0d", sel), 32'(ready_w[sel]), 32'd0);
    endtask

    // bits[i] is the line level expected during the i-th bit interval that starts from here.
    task automatic check_frame(input int sel, input logic [31:0] bits, input int n, input string tag);
        int w;
        for (int i = 0; i < n; i++) begin
            next_tick(w);
            chk($sformatf("%s_bit%0d", tag, i), 32'(tx_w[sel]), 32'(bits[i]));
            for (int k = 0; k < 40 && !baud_tick; k++) step();
            chk($sformatf("%s_hold%0d", tag, i), 32'(tx_w[sel]), 32'(bits[i]));
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[sel]), 32'd1);
        end
        step();
    endtask

    initial begin
        int   w;
        int   cnt;
        logic bad;

        n_checks   = 0;
        n_fails    = 0;
        tick_cnt   = 0;
        tick_prev  = 1'b0;
        baud_tick  = 1'b0;
        tx_valid_a = '0;
        for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(tx_w), 32'hF);
        chk("rst_ready", 32'(ready_w), 32'hF);
        chk("rst_busy", 32'(busy_w), 32'h0);
        rst = 1'b0;
        step();
        step();
        chk("idle_tx", 32'(tx_w), 32'hF);

        // 8N1 0x55
        send(0, 8'h55);
        chk("t1_pre_start", 32'(tx_w[0]), 32'd1);
        check_frame(0, 32'b1010101010, 10, "t1");
        chk("t1_busy_end", 32'(busy_w[0]), 32'd0);
        chk("t1_ready_end", 32'(ready_w[0]), 32'd1);

        // 8E1 and 8O1, 0xA3: parity 0 and 1 respectively
        send(1, 8'hA3);
        check_frame(1, 32'b10101000110, 11, "t2e");
        chk("t2e_busy_end", 32'(busy_w[1]), 32'd0);
        send(2, 8'hA3);
        check_frame(2, 32'b11101000110, 11, "t2o");
        chk("t2o_busy_end", 32'(busy_w[2]), 32'd0);

        // Back-to-back 0x00 then 0xFF with tx_valid held
        if (baud_tick) step();
        data_a[0]     = 8'h00;
        tx_valid_a[0] = 1'b1;
        step();
        data_a[0] = 8'hFF;
        chk("t3_ready_low", 32'(ready_w[0]), 32'd0);
        next_tick(w);
        chk("t3_start", 32'(tx_w[0]), 32'd0);
        chk("t3_rearm", 32'(ready_w[0]), 32'd1);
        step();
        tx_valid_a[0] = 1'b0;
        chk("t3_second_accepted", 32'(ready_w[0]), 32'd0);
        check_frame(0, 32'b1111111110100000000, 19, "t3");
        chk("t3_busy_end", 32'(busy_w[0]), 32'd0);

        // Acceptance in the same cycle as a tick: start waits a full interval
        for (int k = 0; k < 40 && !baud_tick; k++) step();
        data_a[0]     = 8'h3C;
        tx_valid_a[0] = 1'b1;
        step();
        tx_valid_a[0] = 1'b0;
        chk("t4_tx_idle", 32'(tx_w[0]), 32'd1);
        chk("t4_ready_low", 32'(ready_w[0]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 40 && !baud_tick; k++) begin
            step();
            cnt++;
        end
        chk("t4_gap_len", 32'(cnt), 32'd15);
        chk("t4_tx_still_idle", 32'(tx_w[0]), 32'd1);
        step();
        chk("t4_start", 32'(tx_w[0]), 32'd0);
        check_frame(0, 32'b100111100, 9, "t4");
        chk("t4_busy_end", 32'(busy_w[0]), 32'd0);

        // 8N2 0x0F: two stop intervals
        send(3, 8'h0F);
        check_frame(3, 32'b11000011110, 11, "t5");
        chk("t5_busy_end", 32'(busy_w[3]), 32'd0);

        // Reset during DATA of 0x81 with a second byte pending
        send(0, 8'h81);
        next_tick(w);
        next_tick(w);
        next_tick(w);
        chk("t6_pre_rst_tx", 32'(tx_w[0]), 32'd0);
        send(0, 8'h42);
        chk("t6_pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_tx", 32'(tx_w), 32'hF);
        chk("t6_rst_ready", 32'(ready_w), 32'hF);
        chk("t6_rst_busy", 32'(busy_w), 32'h0);
        step();
        step();
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 48; k++) begin
            step();
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1'b1;
        end
        chk("t6_quiet_after_rst", 32'(bad), 32'd0);
        send(0, 8'h01);
        next_tick(w);
        chk("t6_new_start", 32'(tx_w[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage driven by the baud generator's `baud_tick`. It accepts parallel bytes over a valid/ready handshake and shifts each one out as a UART frame: start bit, data bits LSB first, optional parity, then stop bits. A one-entry holding register lets the next byte be queued mid-frame, so back-to-back frames leave no idle gap on the line.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk` in, 1: system clock, same clock that drives the baud generator.
- `rst` in, 1: reset, asynchronous, active-high.
- `baud_tick` in, 1: one-cycle pulse, one per bit period.
- `tx_data` in, DATA_BITS: byte to send.
- `tx_valid` in, 1: `tx_data` is valid.
- `tx_ready` out, 1: holding register is empty.
- `tx` out, 1: serial line, idles high.
- `busy` out, 1: a frame is in flight or a byte is pending.

## Operation
- Handshake:
  - A byte is accepted in the cycle where `tx_valid && tx_ready`.
  - On acceptance, `tx_data` is copied into `hold`, `pending` is set, and the parity bit is computed from `tx_data`.
  - `tx_ready = !pending`.
  - The source holds `tx_data` stable while `tx_valid && !tx_ready`.
- Parity bit: `^data` for even, `~^data` for odd.
- FSM states are IDLE, START, DATA, PARITY, STOP. The FSM advances only in cycles where `baud_tick` = 1. All `tx` changes are registered.
- IDLE, on tick with `pending`:
  - `tx` <= 0.
  - `shreg` <= `hold`, parity copied into `par`, `pending` <= 0.
  - Go to START.
- START, on tick:
  - `tx` <= `shreg[0]`, shift `shreg` right, `bit_cnt` <= 0.
  - Go to DATA.
- DATA, on tick:
  - If `bit_cnt == DATA_BITS-1` and parity is enabled: `tx` <= `par`, go to PARITY.
  - If `bit_cnt == DATA_BITS-1` and parity is disabled: `tx` <= 1, `stop_cnt` <= 0, go to STOP.
  - Otherwise: `tx` <= `shreg[0]`, shift, `bit_cnt++`.
- PARITY, on tick: `tx` <= 1, `stop_cnt` <= 0, go to STOP.
- STOP, on tick:
  - If `stop_cnt == STOP_BITS-1` and `pending`: perform the IDLE load action and go to START. This is a back-to-back frame with no gap.
  - If `stop_cnt == STOP_BITS-1` and not `pending`: go to IDLE, `tx` stays 1.
  - Otherwise: `stop_cnt++`.
- `busy = (state != IDLE) || pending`.
- Widths:
  - `bit_cnt` is $clog2(DATA_BITS) bits.
  - `stop_cnt` is 1 bit.
  - No counter wraps. All end states are compared explicitly.

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, state = IDLE, `pending` = 0.
- Acceptance updates `pending` at the next edge. `tx_ready` falls the cycle after acceptance.
- Start-bit latency:
  - `tx` falls one cycle after the first `baud_tick` that arrives strictly after the acceptance cycle.
  - A tick in the same cycle as acceptance is ignored for starting.
- Bit length: every bit lasts exactly one tick interval. Frame length is `1+DATA_BITS+(PARITY!=0)+STOP_BITS` intervals.
- Re-arming: `tx_ready` re-asserts one cycle after the tick that loads `hold` into `shreg`. A second byte can then be queued during the current frame.
- Simultaneous acceptance and load in one cycle is impossible, because acceptance requires `!pending`.
- If `tx_valid` drops before acceptance, no frame is produced.
- Reset mid-frame:
  - `tx` returns to 1 immediately (asynchronous).
  - The frame is truncated and the pending byte is discarded.
  - After release, the block waits in IDLE.

## Structure
- A shared package `uart_pkg` holds:
  - parity-mode constants `PAR_NONE`=0, `PAR_ODD`=1, `PAR_EVEN`=2;
  - the TX state typedef;
  - the `DATA_BITS`/`STOP_BITS` range limits, shared with the future `uart_rx`.
- No sub-module. The baud generator is instantiated beside this block by the UART top level, not inside it. Parity is computed inline.
- Elaboration-time checks reject `DATA_BITS` outside 5..9, `STOP_BITS` outside 1..2, and `PARITY` > 2.

## Test plan
- 8N1, byte 0x55, tick every 16 cycles → `tx` carries 0,1,0,1,0,1,0,1,0,1, each held for 16 cycles. `busy` falls at the end of the stop bit.
- 8E1, byte 0xA3 → data bits on the line are 1,1,0,0,0,1,0,1, then parity 0, then stop 1. With PARITY=1 the parity bit is 1.
- 8N1, 0x00 then 0xFF with `tx_valid` held high:
  - The second byte is accepted during the first frame and `tx_ready` stays low until its load.
  - The start bit of 0xFF follows the stop bit of 0x00 with no idle interval.
- Acceptance in the same cycle as `baud_tick` → the start bit begins only on the next tick. `tx` stays 1 for one full interval.
- 8N2, byte 0x0F → two stop-bit intervals at 1, then IDLE. Total frame is 11 intervals.
- `rst` asserted during the DATA state of byte 0x81 with a second byte pending:
  - `tx` = 1, `tx_ready` = 1, `busy` = 0 immediately.
  - After release, no frame is emitted until a new acceptance.
